// File: rtl/interp_table_engine.sv
// Multi-channel sample table with a streaming loader and a fixed-latency
// linear-interpolation / zero-order-hold query path on a power-of-two grid.
module interp_table_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int CHANNELS   = 4,
  parameter int FRAC_BITS  = 8,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ADDR_W = $clog2(CHANNELS * DEPTH)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Init_Start,
  input  logic                          Init_Valid,
  input  logic signed [DATA_WIDTH-1:0]  Init_Data,
  output logic                          Init_Ready,
  output logic                          Init_Done,
  input  logic                          Q_Valid,
  output logic                          Q_Ready,
  input  logic [CH_W-1:0]               Q_Channel,
  input  logic [IDX_W+FRAC_BITS-1:0]    Q_X,
  input  logic                          Q_Hold,
  output logic                          R_Valid,
  input  logic                          R_Ready,
  output logic signed [DATA_WIDTH-1:0]  R_Data,
  output logic                          R_Clamped,
  output logic                          R_Error
);

  typedef enum logic [2:0] {UNINIT, LOAD, IDLE, FETCH0, FETCH1, CALC, RESP} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHANNELS * DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

  // y0 + floor((y1 - y0) * frac / 2^FRAC_BITS); the result stays between y0 and y1.
  function automatic logic signed [DATA_WIDTH-1:0] lerp(
    input logic signed [DATA_WIDTH-1:0] y0,
    input logic signed [DATA_WIDTH-1:0] y1,
    input logic [FRAC_BITS-1:0]         frac
  );
    logic signed [DATA_WIDTH:0]             d;
    logic signed [FRAC_BITS:0]              f;
    logic signed [DATA_WIDTH+FRAC_BITS+1:0] p;
    d = {y1[DATA_WIDTH-1], y1} - {y0[DATA_WIDTH-1], y0};
    f = {1'b0, frac};
    p = d * f;
    return y0 + DATA_WIDTH'(p >>> FRAC_BITS);
  endfunction

  state_t                        state;
  logic [ADDR_W-1:0]             wr_ptr;
  logic                          q_rdy_r;

  logic [CH_W-1:0]               ch_p0;
  logic [IDX_W-1:0]              idx_p0;
  logic [FRAC_BITS-1:0]          frac_p0;
  logic                          clamp_p0;
  logic                          err_p0;
  logic signed [DATA_WIDTH-1:0]  y0_p1;

  logic signed [DATA_WIDTH-1:0]  mem [CHANNELS*DEPTH];
  logic signed [DATA_WIDTH-1:0]  rd_data;
  logic [ADDR_W-1:0]             ram_addr;
  logic                          ram_we;

  logic [IDX_W-1:0]              q_idx;
  logic [FRAC_BITS-1:0]          q_frac;
  logic                          q_clamp;
  logic                          q_err;
  logic                          accept;
  logic [IDX_W-1:0]              rd_idx;

  // A reload request always wins over a query offered in the same cycle.
  assign Q_Ready = q_rdy_r & ~Init_Start;
  assign accept  = Q_Valid & Q_Ready;

  assign q_idx   = Q_X[IDX_W+FRAC_BITS-1:FRAC_BITS];
  assign q_frac  = Q_X[FRAC_BITS-1:0];
  assign q_clamp = ({1'b0, q_idx} > {1'b0, LAST_IDX}) ||
                   ((q_idx == LAST_IDX) && (q_frac != '0));
  assign q_err   = ({1'b0, Q_Channel} >= (CH_W+1)'(CHANNELS));

  assign ram_we  = (state == LOAD) && Init_Valid && !Init_Start;

  always_comb begin
    rd_idx = idx_p0;
    if (state == FETCH1 && idx_p0 != LAST_IDX)
      rd_idx = idx_p0 + 1'b1;
    if (ram_we)
      ram_addr = wr_ptr;
    else if (err_p0)
      ram_addr = '0;
    else
      ram_addr = ADDR_W'(int'(ch_p0) * DEPTH + int'(rd_idx));
  end

  always_ff @(posedge CLK) begin
    if (ram_we)
      mem[ram_addr] <= Init_Data;
    rd_data <= mem[ram_addr];
  end

  // Stage p0: query registered at accept, clamp and hold already folded in.
  // Stage p1: first sample captured while the second read is in flight.
  always_ff @(posedge CLK) begin
    if (accept) begin
      ch_p0    <= Q_Channel;
      idx_p0   <= q_clamp ? LAST_IDX : q_idx;
      frac_p0  <= (q_clamp || Q_Hold) ? '0 : q_frac;
      clamp_p0 <= q_clamp;
      err_p0   <= q_err;
    end
    if (state == FETCH1)
      y0_p1 <= rd_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= UNINIT;
      wr_ptr     <= '0;
      Init_Ready <= 1'b0;
      Init_Done  <= 1'b0;
      q_rdy_r    <= 1'b0;
      R_Valid    <= 1'b0;
      R_Data     <= '0;
      R_Clamped  <= 1'b0;
      R_Error    <= 1'b0;
    end else if (Init_Start) begin
      state      <= LOAD;
      wr_ptr     <= '0;
      Init_Ready <= 1'b1;
      Init_Done  <= 1'b0;
      q_rdy_r    <= 1'b0;
      R_Valid    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (Init_Valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_ADDR) begin
              state      <= IDLE;
              Init_Done  <= 1'b1;
              Init_Ready <= 1'b0;
            end
          end
        end
        IDLE: begin
          if (accept) begin
            state   <= FETCH0;
            q_rdy_r <= 1'b0;
          end else begin
            q_rdy_r <= 1'b1;
          end
        end
        FETCH0: state <= FETCH1;
        FETCH1: state <= CALC;
        // Stage p2: second sample arrives, result registered for the response.
        CALC: begin
          state     <= RESP;
          R_Valid   <= 1'b1;
          R_Data    <= err_p0 ? '0 : lerp(y0_p1, rd_data, frac_p0);
          R_Clamped <= clamp_p0 & ~err_p0;
          R_Error   <= err_p0;
        end
        RESP: begin
          if (R_Ready) begin
            state   <= IDLE;
            R_Valid <= 1'b0;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule
